// File: rtl/flag_register.sv
// N/Z/C/V flag register with an in-flight update pipeline from EX to commit.
// Forwards the youngest pending flags to the condition checker.
module flag_register #(
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_e,
  input  logic             flag_write_e,
  input  logic [3:0]       alu_flags_e,
  output logic [3:0]       flags_cond,
  output logic [3:0]       flags_commit,
  output logic             pending,
  output logic [CNT_W-1:0] update_count
);

  localparam int unsigned FW = PIPE_DEPTH * 4;

  // Slot i lives in r_v[i] / r_flags[4*i +: 4]; slot 0 is the youngest.
  logic [PIPE_DEPTH-1:0] r_v;
  logic [FW-1:0]         r_flags;
  logic [3:0]            r_flags_commit;
  logic [CNT_W-1:0]      r_update_count;

  logic                  w_wr;
  logic                  w_adv;
  logic [3:0]            w_slot0_flags;
  logic [3:0]            w_flags_cond;
  logic [PIPE_DEPTH-1:0] w_v_scan;
  logic [FW-1:0]         w_f_scan;

  assign w_wr          = valid_e & flag_write_e & ~flush;
  // A flush squashes the EX write but still moves older updates toward commit.
  assign w_adv         = flush | ~stall;
  assign w_slot0_flags = flush ? 4'b0000 : alu_flags_e;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v            <= '0;
      r_flags        <= '0;
      r_flags_commit <= 4'b0000;
      r_update_count <= '0;
    end else if (w_adv) begin
      r_v     <= PIPE_DEPTH'({r_v, w_wr});
      r_flags <= FW'({r_flags, w_slot0_flags});
      if (r_v[PIPE_DEPTH-1]) begin
        r_flags_commit <= r_flags[FW-1 -: 4];
        r_update_count <= r_update_count + CNT_W'(1);
      end
    end
  end

  // Walk from oldest to youngest so the youngest valid slot wins.
  always_comb begin
    w_flags_cond = r_flags_commit;
    w_v_scan     = r_v;
    w_f_scan     = r_flags;
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      if (w_v_scan[PIPE_DEPTH-1]) begin
        w_flags_cond = w_f_scan[FW-1 -: 4];
      end
      w_v_scan = w_v_scan << 1;
      w_f_scan = w_f_scan << 4;
    end
  end

  assign flags_cond   = w_flags_cond;
  assign flags_commit = r_flags_commit;
  assign pending      = |r_v;
  assign update_count = r_update_count;

endmodule
